// File: rtl/decode_register_field_sequencer_pkg.sv
// ==== decode_pkg: shared states, opcode classes and constants for the reg-field decode front end. Rev 1.0
// ==== Optional feature macro used by importers: DECODE_OPERAND_SIZE_PREFIX_EN
`default_nettype none

package decode_pkg;

  typedef enum logic [1:0] {
    OPCODE = 2'd0,
    MODRM  = 2'd1,
    HOLD   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLASS_MODRM       = 2'd0,
    CLASS_REG_IN_OP   = 2'd1,
    CLASS_REG_IN_OP_W = 2'd2,
    CLASS_UNSUPPORTED = 2'd3
  } opcode_class_e;

  localparam logic [1:0] BIT_WIDTH_16        = 2'b01;
  localparam logic [1:0] BIT_WIDTH_32        = 2'b10;
  localparam logic [7:0] PREFIX_OPERAND_SIZE = 8'h66;
  localparam int         PREFIX_CNT_W        = 4;
  localparam logic [PREFIX_CNT_W-1:0] PREFIX_MAX = 4'd14;

  function automatic logic [1:0] width_code(input logic is_32);
    return is_32 ? BIT_WIDTH_32 : BIT_WIDTH_16;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_register_field_sequencer_if.sv
// ==== decode_register_field_sequencer_if: byte stream in, decoded reg-field bundle out. Rev 1.0
// ==== Sequencer attaches through the slave modport; the byte source/field sink uses master.
`default_nettype none

interface decode_register_field_sequencer_if;
  logic       default_operand_size_32;
  logic       flush;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       field_valid;
  logic       field_ready;
  logic [7:0] opcode;
  logic [1:0] bit_width;
  logic [2:0] register_sequence_code;
  logic       w_in_instruction;
  logic       w;
  logic       has_modrm;
  logic [1:0] mod;
  logic [2:0] rm;
  logic       unsupported;

  modport master (
    output default_operand_size_32, flush, byte_valid, byte_data, field_ready,
    input  byte_ready, field_valid, opcode, bit_width, register_sequence_code,
           w_in_instruction, w, has_modrm, mod, rm, unsupported
  );

  modport slave (
    input  default_operand_size_32, flush, byte_valid, byte_data, field_ready,
    output byte_ready, field_valid, opcode, bit_width, register_sequence_code,
           w_in_instruction, w, has_modrm, mod, rm, unsupported
  );
endinterface

`default_nettype wire

// File: rtl/decode_register_field_sequencer_classifier.sv
// ==== decode_opcode_classifier: combinational opcode class / w / reg-code extraction. Rev 1.0
// ==== Unsupported opcodes return all-zero fields.
`default_nettype none

module decode_opcode_classifier
  import decode_pkg::*;
(
  input  logic [7:0]    op,
  output opcode_class_e op_class,
  output logic          w_in_instruction,
  output logic          w,
  output logic [2:0]    reg_code
);

  always_comb begin
    op_class         = CLASS_UNSUPPORTED;
    w_in_instruction = 1'b0;
    w                = 1'b0;
    reg_code         = 3'b000;
    // ALU r/m forms 0x00-0x3F (op[2]=0) and MOV 0x88-0x8B carry the reg field in mod r/m
    if ((op[7:6] == 2'b00 && !op[2]) || op[7:2] == 6'b100010) begin
      op_class         = CLASS_MODRM;
      w_in_instruction = 1'b1;
      w                = op[0];
    end else if (op[7:5] == 3'b010 || op[7:3] == 5'b10010) begin
      op_class = CLASS_REG_IN_OP;
      reg_code = op[2:0];
    end else if (op[7:4] == 4'hB) begin
      op_class         = CLASS_REG_IN_OP_W;
      w_in_instruction = 1'b1;
      w                = op[3];
      reg_code         = op[2:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/decode_register_field_sequencer.sv
// ==== decode_register_field_sequencer: prefix/opcode/modrm byte sequencer holding reg-field decode inputs. Rev 1.0
// ==== Optional: DECODE_OPERAND_SIZE_PREFIX_EN enables 0x66 operand-size prefix handling.
`default_nettype none

module decode_register_field_sequencer
  import decode_pkg::*;
(
  input  logic clock,
  input  logic reset,
  decode_register_field_sequencer_if.slave bus
);

  opcode_class_e cls;
  logic          cls_w_in;
  logic          cls_w;
  logic [2:0]    cls_reg;

  decode_opcode_classifier u_classifier (
    .op               (bus.byte_data),
    .op_class         (cls),
    .w_in_instruction (cls_w_in),
    .w                (cls_w),
    .reg_code         (cls_reg)
  );

  state_e     state_q, state_d;
  logic       field_valid_q, field_valid_d;
  logic [7:0] opcode_q, opcode_d;
  logic [1:0] bit_width_q, bit_width_d;
  logic [2:0] reg_q, reg_d;
  logic       w_in_q, w_in_d;
  logic       w_q, w_d;
  logic       has_modrm_q, has_modrm_d;
  logic [1:0] mod_q, mod_d;
  logic [2:0] rm_q, rm_d;
  logic       unsupported_q, unsupported_d;
  logic       width_sel;

`ifdef DECODE_OPERAND_SIZE_PREFIX_EN
  logic                    size_toggle_q, size_toggle_d;
  logic [PREFIX_CNT_W-1:0] prefix_cnt_q, prefix_cnt_d;
  logic                    is_prefix;

  // Once PREFIX_MAX prefixes are absorbed, another 0x66 falls through to the classifier as unsupported
  assign is_prefix = (bus.byte_data == PREFIX_OPERAND_SIZE) && (prefix_cnt_q < PREFIX_MAX);
  assign width_sel = bus.default_operand_size_32 ^ size_toggle_q;
`else
  assign width_sel = bus.default_operand_size_32;
`endif

  always_comb begin
    state_d       = state_q;
    field_valid_d = field_valid_q;
    opcode_d      = opcode_q;
    bit_width_d   = bit_width_q;
    reg_d         = reg_q;
    w_in_d        = w_in_q;
    w_d           = w_q;
    has_modrm_d   = has_modrm_q;
    mod_d         = mod_q;
    rm_d          = rm_q;
    unsupported_d = unsupported_q;
`ifdef DECODE_OPERAND_SIZE_PREFIX_EN
    size_toggle_d = size_toggle_q;
    prefix_cnt_d  = prefix_cnt_q;
`endif
    if (bus.flush) begin
      state_d       = OPCODE;
      field_valid_d = 1'b0;
`ifdef DECODE_OPERAND_SIZE_PREFIX_EN
      size_toggle_d = 1'b0;
      prefix_cnt_d  = '0;
`endif
    end else begin
      case (state_q)
        OPCODE: begin
          if (bus.byte_valid) begin
`ifdef DECODE_OPERAND_SIZE_PREFIX_EN
            if (is_prefix) begin
              size_toggle_d = 1'b1;
              prefix_cnt_d  = prefix_cnt_q + 4'd1;
            end else
`endif
            begin
`ifdef DECODE_OPERAND_SIZE_PREFIX_EN
              prefix_cnt_d  = '0;
`endif
              opcode_d      = bus.byte_data;
              bit_width_d   = width_code(width_sel);
              unsupported_d = (cls == CLASS_UNSUPPORTED);
              w_in_d        = cls_w_in;
              w_d           = cls_w;
              reg_d         = cls_reg;
              has_modrm_d   = 1'b0;
              mod_d         = 2'b00;
              rm_d          = 3'b000;
              if (cls == CLASS_MODRM) begin
                state_d = MODRM;
              end else begin
                state_d       = HOLD;
                field_valid_d = 1'b1;
              end
            end
          end
        end
        MODRM: begin
          if (bus.byte_valid) begin
            reg_d         = bus.byte_data[5:3];
            mod_d         = bus.byte_data[7:6];
            rm_d          = bus.byte_data[2:0];
            has_modrm_d   = 1'b1;
            state_d       = HOLD;
            field_valid_d = 1'b1;
          end
        end
        HOLD: begin
          if (bus.field_ready) begin
            state_d       = OPCODE;
            field_valid_d = 1'b0;
`ifdef DECODE_OPERAND_SIZE_PREFIX_EN
            size_toggle_d = 1'b0;
`endif
          end
        end
        default: begin
          state_d       = OPCODE;
          field_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= OPCODE;
      field_valid_q <= 1'b0;
      opcode_q      <= 8'h00;
      bit_width_q   <= 2'b00;
      reg_q         <= 3'b000;
      w_in_q        <= 1'b0;
      w_q           <= 1'b0;
      has_modrm_q   <= 1'b0;
      mod_q         <= 2'b00;
      rm_q          <= 3'b000;
      unsupported_q <= 1'b0;
`ifdef DECODE_OPERAND_SIZE_PREFIX_EN
      size_toggle_q <= 1'b0;
      prefix_cnt_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      field_valid_q <= field_valid_d;
      opcode_q      <= opcode_d;
      bit_width_q   <= bit_width_d;
      reg_q         <= reg_d;
      w_in_q        <= w_in_d;
      w_q           <= w_d;
      has_modrm_q   <= has_modrm_d;
      mod_q         <= mod_d;
      rm_q          <= rm_d;
      unsupported_q <= unsupported_d;
`ifdef DECODE_OPERAND_SIZE_PREFIX_EN
      size_toggle_q <= size_toggle_d;
      prefix_cnt_q  <= prefix_cnt_d;
`endif
    end
  end

  assign bus.byte_ready             = (state_q != HOLD);
  assign bus.field_valid            = field_valid_q;
  assign bus.opcode                 = opcode_q;
  assign bus.bit_width              = bit_width_q;
  assign bus.register_sequence_code = reg_q;
  assign bus.w_in_instruction       = w_in_q;
  assign bus.w                      = w_q;
  assign bus.has_modrm              = has_modrm_q;
  assign bus.mod                    = mod_q;
  assign bus.rm                     = rm_q;
  assign bus.unsupported            = unsupported_q;

endmodule

`default_nettype wire
